// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One product/quotient bit per cycle, then a single sign-fixup cycle.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   yreg;
    logic [CNT_W-1:0]   cnt;
    logic               sx, sy, is_div, dz;

    logic               op_signed, y_zero, accept;
    logic [WIDTH-1:0]   abs_x, abs_y;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign op_signed = ~op[0];
    assign y_zero    = (op_y == '0);
    assign accept    = start & ~flush & ~op[2];
    assign abs_x     = (op_signed && op_x[WIDTH-1]) ? -op_x : op_x;
    assign abs_y     = (op_signed && op_y[WIDTH-1]) ? -op_y : op_y;
    assign busy      = (state != IDLE);

    // MUL: acc = {partial product, remaining multiplier bits}, shifted right.
    // DIV: acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, yreg};
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, yreg};
    assign prod_neg  = -acc;

    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
        if (dz) begin
            fix_hi = acc[2*WIDTH-1:WIDTH];
            fix_lo = acc[WIDTH-1:0];
        end else if (is_div) begin
            fix_lo = (sx ^ sy) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = sx ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else if (sx ^ sy) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = op[1] ? (y_zero ? FIX : DIV) : MUL;
            MUL, DIV: begin
                if (flush) state_nxt = IDLE;
                else if (cnt == CNT_W'(1)) state_nxt = FIX;
            end
            FIX: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            acc         <= '0;
            yreg        <= '0;
            cnt         <= '0;
            sx          <= 1'b0;
            sy          <= 1'b0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                sx     <= op_signed & op_x[WIDTH-1];
                                sy     <= op_signed & op_y[WIDTH-1];
                                is_div <= op[1];
                                dz     <= op[1] & y_zero;
                                cnt    <= CNT_W'(WIDTH);
                                yreg   <= op[1] ? abs_y : abs_x;
                                // A zero divisor preloads the final HI/LO image directly.
                                if (op[1] && y_zero)
                                    acc <= {op_x, {WIDTH{1'b1}}};
                                else if (op[1])
                                    acc <= {{WIDTH{1'b0}}, abs_x};
                                else
                                    acc <= {{WIDTH{1'b0}}, abs_y};
                            end
                            3'd4:    hi <= op_x;
                            3'd5:    lo <= op_x;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (!flush) begin
                        acc <= acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                                      : {1'b0, acc[2*WIDTH-1:1]};
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV: begin
                    if (!flush) begin
                        acc <= div_diff[WIDTH]
                             ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                             : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    cnt <= '0;
                    if (!flush) begin
                        hi          <= fix_hi;
                        lo          <= fix_lo;
                        done        <= 1'b1;
                        div_by_zero <= dz;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: vector table for WIDTH=32 plus
// hand-written flush/abort/reset sequences and a WIDTH=8 instance.
module tb_mips_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] op_x = '0, op_y = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_x(op_x), .op_y(op_y),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    mips_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .op_x(x8), .op_y(y8),
        .flush(flush8), .busy(busy8), .done(done8), .div_by_zero(dz8),
        .hi(hi8), .lo(lo8)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] x, y, hi, lo;
        logic        dz;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one mul/div; lat = edges after the start edge until done is seen.
    task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt, output logic dz_seen);
        @(negedge clk);
        start = 1'b1; op = o; op_x = x; op_y = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            bcnt += int'(busy);
            @(negedge clk);
            lat++;
        end
        dz_seen = div_by_zero;
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        @(negedge clk);
        start8 = 1'b1; op8 = o; x8 = x; y8 = y;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat, bcnt, exp_lat;
        logic dzs, seen;

        vt[0]  = '{"multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1]  = '{"mult_m3x5", 3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vt[2]  = '{"div_m7d2",  3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3]  = '{"divu_7d2",  3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vt[4]  = '{"div_min_m1",3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[5]  = '{"divu_5d0",  3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vt[6]  = '{"div_7dm2",  3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vt[7]  = '{"multu_2p16",3'd1, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
        vt[8]  = '{"mult_m1m1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
        vt[9]  = '{"div_m5d0",  3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vt[10] = '{"mult_min2", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_dz", 64'(div_by_zero), 64'h0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            exp_lat = vt[i].dz ? 1 : 33;
            run32(vt[i].op, vt[i].x, vt[i].y, lat, bcnt, dzs);
            chk({vt[i].name, "_lat"}, 64'(lat), 64'(exp_lat));
            chk({vt[i].name, "_busy"}, 64'(bcnt), 64'(exp_lat));
            chk({vt[i].name, "_hi"}, 64'(hi), 64'(vt[i].hi));
            chk({vt[i].name, "_lo"}, 64'(lo), 64'(vt[i].lo));
            chk({vt[i].name, "_dz"}, 64'(dzs), 64'(vt[i].dz));
            @(negedge clk);
            chk({vt[i].name, "_pulse"}, 64'(done), 64'h0);
        end

        // MTHI then MTLO in consecutive idle cycles
        @(negedge clk);
        start = 1'b1; op = 3'd4; op_x = 32'h1234;
        @(negedge clk);
        seen = done | busy;
        op = 3'd5; op_x = 32'h5678;
        @(negedge clk);
        seen |= done | busy;
        start = 1'b0;
        @(negedge clk);
        seen |= done | busy;
        chk("mt_hi", 64'(hi), 64'h1234);
        chk("mt_lo", 64'(lo), 64'h5678);
        chk("mt_no_done_busy", 64'(seen), 64'h0);

        // MULT aborted by flush on edge 10
        start = 1'b1; op = 3'd0; op_x = 32'd3; op_y = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'h0);
        seen = 1'b0;
        repeat (40) begin
            seen |= done;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(seen), 64'h0);
        chk("flush_hi", 64'(hi), 64'h1234);
        chk("flush_lo", 64'(lo), 64'h5678);

        // flush wins over an idle MTHI
        start = 1'b1; op = 3'd4; op_x = 32'hAAAA; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_hi", 64'(hi), 64'h1234);

        // a start pulse while busy is ignored
        start = 1'b1; op = 3'd3; op_x = 32'd100; op_y = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd4; op_x = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_start_lat", 64'(lat), 64'd33);
        chk("busy_start_hi", 64'(hi), 64'd2);
        chk("busy_start_lo", 64'(lo), 64'd14);
        repeat (2) @(negedge clk);
        chk("busy_start_hi_after", 64'(hi), 64'd2);

        // asynchronous reset in the middle of a DIV
        start = 1'b1; op = 3'd2; op_x = 32'd50; op_y = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'h0);
        chk("arst_lo", 64'(lo), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            seen |= done | busy;
            @(negedge clk);
        end
        chk("arst_no_done", 64'(seen), 64'h0);

        // WIDTH=8 instance
        run8(3'd1, 8'hFF, 8'hFF, lat);
        chk("w8_multu_lat", 64'(lat), 64'd9);
        chk("w8_multu_hi", 64'(hi8), 64'hFE);
        chk("w8_multu_lo", 64'(lo8), 64'h01);
        run8(3'd2, 8'h80, 8'hFF, lat);
        chk("w8_div_lat", 64'(lat), 64'd9);
        chk("w8_div_hi", 64'(hi8), 64'h00);
        chk("w8_div_lo", 64'(lo8), 64'h80);
        chk("w8_div_dz", 64'(dz8), 64'h0);
        run8(3'd2, 8'hF9, 8'h02, lat);
        chk("w8_div_m7_hi", 64'(hi8), 64'hFF);
        chk("w8_div_m7_lo", 64'(lo8), 64'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
